// File: rtl/maze_pkg.sv
// Shared maze types: coordinate width, motion FSM states and keypad direction bit positions.
package maze_pkg;
    typedef logic [9:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        PROP_X,
        HOLD_X,
        PROP_Y,
        HOLD_Y,
        DONE
    } motion_state_t;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;
endpackage

// File: rtl/player_motion_ctrl_if.sv
// Keypad/vsync inputs, wall-deny verdicts, proposed box and committed position of the player.
interface player_motion_ctrl_if;
    import maze_pkg::*;

    logic       frame_tick;
    logic [3:0] dir;
    logic       deny_left;
    logic       deny_right;
    logic       deny_up;
    logic       deny_down;
    coord_t     left;
    coord_t     right;
    coord_t     top;
    coord_t     bottom;
    coord_t     pos_x;
    coord_t     pos_y;
    logic       busy;
    logic       moved;

    modport master (
        output frame_tick, dir, deny_left, deny_right, deny_up, deny_down,
        input  left, right, top, bottom, pos_x, pos_y, busy, moved
    );

    modport slave (
        input  frame_tick, dir, deny_left, deny_right, deny_up, deny_down,
        output left, right, top, bottom, pos_x, pos_y, busy, moved
    );
endinterface

// File: rtl/axis_stepper.sv
// One-axis move proposal: steps pos toward the single requested direction if the box stays in range.
module axis_stepper
    import maze_pkg::*;
#(
    parameter int unsigned STEP = 1,
    parameter int unsigned SIZE = 16,
    parameter int unsigned MAX  = 639
) (
    input  coord_t pos,
    input  logic   minus,
    input  logic   plus,
    output coord_t cand,
    output logic   valid,
    output logic   neg
);
    // Bounds are compared one bit wider so the check itself can never wrap.
    logic [10:0] pos_w;
    assign pos_w = {1'b0, pos};
    assign neg   = minus;

    always_comb begin
        cand  = pos;
        valid = 1'b0;
        if (minus && !plus && pos_w >= 11'(STEP)) begin
            cand  = pos - coord_t'(STEP);
            valid = 1'b1;
        end else if (plus && !minus && (pos_w + 11'(SIZE - 1 + STEP)) <= 11'(MAX)) begin
            cand  = pos + coord_t'(STEP);
            valid = 1'b1;
        end
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player mover: proposes x then y steps to the deny checkers, settles, then commits or drops.
module player_motion_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned START_X = 10,
    parameter int unsigned START_Y = 10,
    parameter int unsigned SIZE    = 16,
    parameter int unsigned STEP    = 1,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned X_MAX   = 639,
    parameter int unsigned Y_MAX   = 479
) (
    input logic           Clk,
    input logic           Reset,
    player_motion_ctrl_if.slave bus
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    motion_state_t state;
    logic [3:0]    dir_q;
    coord_t        pos_x, pos_y, cx, cy;
    logic [CW-1:0] cnt;
    logic          neg_q, moved_x, busy_q, moved_q;
    coord_t        x_cand, y_cand;
    logic          x_valid, y_valid, x_neg, y_neg, deny_sel;

    axis_stepper #(.STEP(STEP), .SIZE(SIZE), .MAX(X_MAX)) u_x (
        .pos(pos_x), .minus(dir_q[DIR_LEFT]), .plus(dir_q[DIR_RIGHT]),
        .cand(x_cand), .valid(x_valid), .neg(x_neg)
    );

    axis_stepper #(.STEP(STEP), .SIZE(SIZE), .MAX(Y_MAX)) u_y (
        .pos(pos_y), .minus(dir_q[DIR_UP]), .plus(dir_q[DIR_DOWN]),
        .cand(y_cand), .valid(y_valid), .neg(y_neg)
    );

    // Only the checker matching the held proposal's direction is consulted.
    assign deny_sel = (state == HOLD_X) ? (neg_q ? bus.deny_left : bus.deny_right)
                                        : (neg_q ? bus.deny_up   : bus.deny_down);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            dir_q   <= '0;
            pos_x   <= coord_t'(START_X);
            pos_y   <= coord_t'(START_Y);
            cx      <= coord_t'(START_X);
            cy      <= coord_t'(START_Y);
            cnt     <= '0;
            neg_q   <= 1'b0;
            moved_x <= 1'b0;
            busy_q  <= 1'b0;
            moved_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    moved_q <= 1'b0;
                    if (bus.frame_tick) begin
                        dir_q   <= bus.dir;
                        busy_q  <= 1'b1;
                        moved_x <= 1'b0;
                        state   <= PROP_X;
                    end
                end
                PROP_X: begin
                    cnt <= '0;
                    if (x_valid) begin
                        cx    <= x_cand;
                        neg_q <= x_neg;
                        state <= HOLD_X;
                    end else begin
                        state <= PROP_Y;
                    end
                end
                HOLD_X: begin
                    if (cnt == CNT_LAST) begin
                        if (!deny_sel) begin
                            pos_x   <= cx;
                            moved_x <= 1'b1;
                        end else begin
                            cx <= pos_x;
                        end
                        state <= PROP_Y;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PROP_Y: begin
                    cnt <= '0;
                    if (y_valid) begin
                        cy    <= y_cand;
                        neg_q <= y_neg;
                        state <= HOLD_Y;
                    end else begin
                        moved_q <= moved_x;
                        state   <= DONE;
                    end
                end
                HOLD_Y: begin
                    if (cnt == CNT_LAST) begin
                        if (!deny_sel) begin
                            pos_y   <= cy;
                            moved_q <= 1'b1;
                        end else begin
                            cy      <= pos_y;
                            moved_q <= moved_x;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    moved_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.left   = cx;
    assign bus.right  = cx + coord_t'(SIZE - 1);
    assign bus.top    = cy;
    assign bus.bottom = cy + coord_t'(SIZE - 1);
    assign bus.pos_x  = pos_x;
    assign bus.pos_y  = pos_y;
    assign bus.busy   = busy_q;
    assign bus.moved  = moved_q;
endmodule
